// File: rtl/agc_multi_ch_pkg.sv
// agc_multi_ch_pkg: shared FSM state type and width helper for the multi-channel AGC.
package agc_multi_ch_pkg;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/agc_multi_ch_gain_update.sv
// agc_multi_ch_gain_update: LMS-style gain step toward target |y|, clamped to [GAIN_MIN,GAIN_MAX].
module agc_multi_ch_gain_update #(
    parameter int IN_FRAC  = 6,
    parameter int GAIN_W   = 18,
    parameter int GAIN_MIN = 64,
    parameter int GAIN_MAX = 262143,
    parameter int OUT_W    = 32
) (
    input  logic [GAIN_W-1:0]       gain,
    input  logic signed [OUT_W-1:0] y,
    input  logic [OUT_W-2:0]        target_lvl,
    input  logic [3:0]              mu_shift,
    output logic [GAIN_W-1:0]       gain_new,
    output logic                    sat
);
    localparam int SW = OUT_W + 2;
    localparam logic signed [SW-1:0] G_MIN = SW'(GAIN_MIN);
    localparam logic signed [SW-1:0] G_MAX = SW'(GAIN_MAX);
    logic [OUT_W-1:0]        y_neg;
    logic [OUT_W-2:0]        mag;
    logic [7:0]              sh;
    logic signed [OUT_W:0]   err, step;
    logic signed [SW-1:0]    sum;
    assign y_neg = -y;
    // negating the most negative value wraps back to itself; saturate it instead
    assign mag = y[OUT_W-1] ? (y_neg[OUT_W-1] ? '1 : y_neg[OUT_W-2:0]) : y[OUT_W-2:0];
    assign err = $signed({2'b0, target_lvl}) - $signed({2'b0, mag});
    assign sh = 8'(mu_shift) + 8'(IN_FRAC);
    assign step = err >>> sh;
    assign sum = $signed({{(SW-GAIN_W){1'b0}}, gain}) + SW'(step);
    assign sat = (sum < G_MIN) || (sum > G_MAX);
    assign gain_new = (sum < G_MIN) ? GAIN_W'(GAIN_MIN) : (sum > G_MAX) ? GAIN_W'(GAIN_MAX) : sum[GAIN_W-1:0];
endmodule

// File: rtl/agc_multi_ch.sv
// agc_multi_ch: time-multiplexed AGC, per-channel gain store, 2-stage multiply/update pipeline.
module agc_multi_ch
    import agc_multi_ch_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int IN_W      = 13,
    parameter int IN_FRAC   = 6,
    parameter int GAIN_W    = 18,
    parameter int GAIN_FRAC = 12,
    parameter int GAIN_INIT = 1 << GAIN_FRAC,
    parameter int GAIN_MIN  = 64,
    parameter int GAIN_MAX  = 262143,
    localparam int CH_W     = ch_width(NUM_CH),
    localparam int OUT_W    = IN_W + GAIN_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    soft_clear,
    input  logic                    freeze,
    input  logic [3:0]              mu_shift,
    input  logic [OUT_W-2:0]        target_lvl,
    input  logic                    in_valid,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    sat_flag
);
    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);
    state_t                  state;
    logic [CH_W-1:0]         cnt;
    logic [GAIN_W-1:0]       gain_mem [NUM_CH];
    logic                    p0_v, p1_v, valid_q, sat_q;
    logic [CH_W-1:0]         p0_ch, p1_ch;
    logic signed [IN_W-1:0]  p0_d;
    logic signed [OUT_W-1:0] p1_y, y_s1;
    logic [GAIN_W-1:0]       p1_g, g_rd, g_new;
    logic                    g_sat, accept, wr_en;
    assign in_ready = (state == ST_RUN);
    assign accept = in_valid & in_ready & clk_enable & ({1'b0, in_ch} < NCH);
    // write-backs are dropped while clearing so in-flight samples cannot corrupt the re-initialised store
    assign wr_en = clk_enable & p1_v & ~freeze & ~soft_clear & (state == ST_RUN);
    assign g_rd = (wr_en && p1_ch == p0_ch) ? g_new : gain_mem[p0_ch];
    assign y_s1 = OUT_W'(p0_d) * OUT_W'($signed({1'b0, g_rd}));
    assign out_valid = valid_q & clk_enable;
    assign sat_flag = sat_q & out_valid;
    agc_multi_ch_gain_update #(
        .IN_FRAC(IN_FRAC), .GAIN_W(GAIN_W), .GAIN_MIN(GAIN_MIN), .GAIN_MAX(GAIN_MAX), .OUT_W(OUT_W)
    ) u_upd (
        .gain(p1_g), .y(p1_y), .target_lvl(target_lvl), .mu_shift(mu_shift), .gain_new(g_new), .sat(g_sat)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            cnt <= '0;
        end else if (clk_enable) begin
            if (soft_clear) begin
                state <= ST_INIT;
                cnt <= '0;
            end else if (state == ST_INIT) begin
                cnt <= (cnt == CH_W'(NUM_CH-1)) ? '0 : cnt + 1'b1;
                if (cnt == CH_W'(NUM_CH-1)) state <= ST_RUN;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (clk_enable && state == ST_INIT) gain_mem[cnt] <= GAIN_W'(GAIN_INIT);
        else if (wr_en) gain_mem[p1_ch] <= g_new;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {p0_v, p1_v, valid_q, sat_q} <= '0;
            {p0_ch, p1_ch, out_ch} <= '0;
            p0_d <= '0;
            p1_y <= '0;
            p1_g <= '0;
            out_data <= '0;
        end else if (clk_enable) begin
            p0_v <= accept;
            if (accept) begin
                p0_ch <= in_ch;
                p0_d <= in_data;
            end
            p1_v <= p0_v;
            p1_ch <= p0_ch;
            p1_y <= y_s1;
            p1_g <= g_rd;
            valid_q <= p1_v;
            sat_q <= p1_v & g_sat;
            if (p1_v) begin
                out_ch <= p1_ch;
                out_data <= p1_y;
            end
        end
    end
endmodule
